// File: rtl/bus_pkg.sv
// Shared bus encodings for the LLC bus responder and its peers.
// Holds operation/snoop-result enums and line-alignment helpers.
package bus_pkg;

    typedef enum logic [2:0] {
        OpRead       = 3'd1,
        OpWrite      = 3'd2,
        OpInvalidate = 3'd3,
        OpRwim       = 3'd4
    } bus_op_t;

    typedef enum logic [1:0] {
        SnpNohit = 2'd0,
        SnpHit   = 2'd1,
        SnpHitm  = 2'd2
    } snp_rslt_t;

    localparam int unsigned LineOffsetBits = 6;
    localparam int unsigned LineBytes      = 1 << LineOffsetBits;

    // Mask that clears the line-offset bits; callers truncate to their address width.
    function automatic logic [63:0] line_mask64(input int unsigned offset_bits);
        return ~((64'd1 << offset_bits) - 64'd1);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OpRead, OpWrite, OpInvalidate, OpRwim: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/llc_bus_responder.sv
// Bus-side responder: accepts one LLC bus operation, snoops peers, performs any
// required memory transaction and returns the snoop result to the LLC.
module llc_bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS        = 32,
    parameter int unsigned BYTE_OFFSET_BITS = LineOffsetBits,
    parameter int unsigned SNOOP_TIMEOUT    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 snp_valid,
    output logic [2:0]           snp_op,
    output logic [ADDR_BITS-1:0] snp_addr,
    input  logic                 snp_rsp_valid,
    input  logic [1:0]           snp_rsp,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_done,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_snoop
);

    localparam int unsigned CntBits = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [CntBits-1:0] CntMax = CntBits'(SNOOP_TIMEOUT);
    localparam logic [ADDR_BITS-1:0] LineMask = ADDR_BITS'(line_mask64(BYTE_OFFSET_BITS));

    typedef enum logic [2:0] {
        StIdle,
        StSnoop,
        StWaitSnp,
        StMemWb,
        StMemRd,
        StMemWr,
        StResp
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    snp_rslt_t              rslt_q, rslt_d;
    logic [CntBits-1:0]     cnt_q, cnt_d;
    logic                   snp_resolved;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 3'd0;
            addr_q  <= '0;
            rslt_q  <= SnpNohit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rslt_q  <= rslt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        rslt_d       = rslt_q;
        cnt_d        = cnt_q;
        snp_resolved = 1'b0;
        req_ready    = 1'b0;
        snp_valid    = 1'b0;
        mem_valid    = 1'b0;
        mem_we       = 1'b0;
        rsp_valid    = 1'b0;
        rsp_snoop    = SnpNohit;

        case (state_q)
            StIdle: begin
                req_ready = ~rst;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr & LineMask;
                    rslt_d  = SnpNohit;
                    cnt_d   = '0;
                    state_d = op_is_legal(req_op) ? StSnoop : StResp;
                end
            end
            StSnoop: begin
                snp_valid = 1'b1;
                cnt_d     = '0;
                state_d   = StWaitSnp;
            end
            StWaitSnp: begin
                // A response in the final counted cycle still beats the timeout.
                if (snp_rsp_valid) begin
                    rslt_d       = (snp_rsp == 2'd3) ? SnpNohit : snp_rslt_t'(snp_rsp);
                    snp_resolved = 1'b1;
                end else if (cnt_q == CntMax) begin
                    rslt_d       = SnpNohit;
                    snp_resolved = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (snp_resolved) begin
                    case (op_q)
                        OpInvalidate: state_d = StResp;
                        OpWrite:      state_d = StMemWr;
                        default:      state_d = (rslt_d == SnpHitm) ? StMemWb : StMemRd;
                    endcase
                end
            end
            StMemWb: begin
                // Peer supplies the data, so the writeback completes the operation.
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                if (mem_done) state_d = StResp;
            end
            StMemRd: begin
                mem_valid = 1'b1;
                if (mem_done) state_d = StResp;
            end
            StMemWr: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                if (mem_done) state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_snoop = rslt_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign snp_op   = op_q;
    assign snp_addr = addr_q;
    assign mem_addr = addr_q;

endmodule
